// File: rtl/arbiter_rr_if.sv
// Channel-side bus of the round-robin block arbiter: per-channel words with
// req/eob/ack handshake, the trigger request and the serialized output stream.
interface arbiter_rr_if #(
  parameter int unsigned NCH = 16
) ();
  logic [16*NCH-1:0] data;
  logic [NCH-1:0]    req;
  logic [NCH-1:0]    eob;
  logic [NCH-1:0]    ack;
  logic              trigger;
  logic [15:0]       dout;
  logic              kchar;
  logic              err_len;

  modport master (
    output data, req, eob, trigger,
    input  ack, dout, kchar, err_len
  );

  modport slave (
    input  data, req, eob, trigger,
    output ack, dout, kchar, err_len
  );
endinterface

// File: rtl/arbiter_rr.sv
// Round-robin block arbiter merging NCH 16-bit channels into one K-coded stream.
// Optional per-block header word enabled by defining ARB_HEADER_EN.
module arbiter_rr #(
  parameter int unsigned NCH      = 16,
  parameter int unsigned MAXLEN   = 255,
  parameter logic [15:0] CH_COMMA = 16'h00BC,
  parameter logic [15:0] CH_TRIG  = 16'h801C
) (
  input  logic       clk,
  input  logic       reset,
  arbiter_rr_if.slave bus
);

  localparam int unsigned NR = NCH - 1;

  typedef enum logic [1:0] {
    IDLE,
`ifdef ARB_HEADER_EN
    HDR,
`endif
    BLOCK
  } state_t;

  state_t      state;
  logic [3:0]  cur;
  logic [15:0] cnt;

  logic        req_cur;
  logic        eob_cur;
  logic [15:0] word_cur;
  logic        ack_state;
  logic        xfer;
  logic [15:0] cnt_now;
  logic        forced;
  logic [3:0]  cur_inc;
  logic [3:0]  nxt;
  logic        found;
  logic [NR-1:0] rot;
  logic [4:0]  sum;

  always_comb begin
    req_cur  = 1'b0;
    eob_cur  = 1'b0;
    word_cur = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (cur == 4'(i)) begin
        req_cur  = bus.req[i];
        eob_cur  = bus.eob[i];
        word_cur = bus.data[16*i +: 16];
      end
    end
  end

`ifdef ARB_HEADER_EN
  assign ack_state = (state == BLOCK);
`else
  assign ack_state = (state == IDLE) || (state == BLOCK);
`endif

  assign xfer = ack_state && req_cur && !bus.trigger && !reset;

  always_comb begin
    bus.ack = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      bus.ack[i] = xfer && (cur == 4'(i));
    end
  end

  assign cur_inc = (cur == 4'(NCH - 1)) ? '0 : cur + 4'd1;
  assign cnt_now = ((state == BLOCK) ? cnt : '0) + 16'd1;
  assign forced  = xfer && !eob_cur && (cnt_now == 16'(MAXLEN));

  // rot[k] is the request of channel cur+1+k (mod NCH), so the lowest set bit
  // is the next channel in rotating order without variable indexing.
  assign rot = NR'({bus.req, bus.req} >> ({1'b0, cur} + 5'd1));

  always_comb begin
    found = 1'b0;
    sum   = {1'b0, cur};
    for (int unsigned k = 0; k < NR; k++) begin
      if (!found && rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, cur} + 5'(k + 1);
      end
    end
    if (sum >= 5'(NCH)) begin
      sum = sum - 5'(NCH);
    end
    nxt = sum[3:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cur         <= '0;
      cnt         <= '0;
      bus.dout    <= CH_COMMA;
      bus.kchar   <= 1'b1;
      bus.err_len <= 1'b0;
    end else begin
      bus.err_len <= forced;

      if (bus.trigger) begin
        bus.dout  <= CH_TRIG;
        bus.kchar <= 1'b1;
      end else if (xfer) begin
        bus.dout  <= word_cur;
        bus.kchar <= 1'b0;
`ifdef ARB_HEADER_EN
      end else if (state == HDR) begin
        bus.dout  <= 16'hF000 | {12'h000, cur};
        bus.kchar <= 1'b0;
`endif
      end else begin
        bus.dout  <= CH_COMMA;
        bus.kchar <= 1'b1;
      end

      // A trigger freezes state, pointer and counter for its whole duration.
      if (!bus.trigger) begin
        case (state)
          IDLE: begin
            if (req_cur) begin
`ifdef ARB_HEADER_EN
              state <= HDR;
`else
              cnt <= cnt_now;
              if (eob_cur || forced) begin
                cur <= cur_inc;
              end else begin
                state <= BLOCK;
              end
`endif
            end else if (found) begin
              cur <= nxt;
            end
          end
`ifdef ARB_HEADER_EN
          HDR: begin
            state <= BLOCK;
            cnt   <= '0;
          end
`endif
          BLOCK: begin
            if (xfer) begin
              cnt <= cnt_now;
              if (eob_cur || forced) begin
                state <= IDLE;
                cur   <= cur_inc;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
